// File: rtl/frame_buffer_pkg.sv
// Shared types and helpers for the frame-buffer arbiter: FSM states, requester identity,
// frame sizing and the burst arbitration rule.
package frame_buffer_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT_DONE
  } arb_state_t;

  typedef enum logic {
    REQ_WRITE,
    REQ_READ
  } requester_t;

  function automatic int unsigned frame_words(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  // Only meaningful when at least one request is active; urgency beats round-robin.
  function automatic requester_t pick_winner(input logic       wr_req,
                                             input logic       rd_req,
                                             input logic       rd_urgent,
                                             input requester_t last_served);
    if (rd_urgent && rd_req) return REQ_READ;
    if (wr_req && !rd_req) return REQ_WRITE;
    if (rd_req && !wr_req) return REQ_READ;
    return (last_served == REQ_READ) ? REQ_WRITE : REQ_READ;
  endfunction

endpackage

// File: rtl/burst_address_counter.sv
// Per-requester frame-buffer word address: advances one burst per completed burst, wraps at
// the frame size, and restarts at zero on the first grant after a start-of-frame pulse.
module burst_address_counter #(
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned BURST_LEN   = 32,
  parameter int unsigned ADDR_WIDTH  = 21
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  advance,
  input  logic                  sof,
  input  logic                  take,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam logic [ADDR_WIDTH-1:0] FrameWordsA = ADDR_WIDTH'(FRAME_WORDS);
  localparam logic [ADDR_WIDTH-1:0] BurstLenA   = ADDR_WIDTH'(BURST_LEN);

  logic [ADDR_WIDTH-1:0] count_q, count_d, count_inc;
  logic                  pending_q, pending_d;

  always_comb begin
    count_inc = count_q + BurstLenA;
    count_d   = count_q;
    if (take && pending_q) begin
      count_d = '0;
    end else if (advance) begin
      count_d = (count_inc == FrameWordsA) ? '0 : count_inc;
    end

    // A pulse landing on the grant cycle belongs to the next burst, so it wins over the clear.
    pending_d = pending_q;
    if (sof) begin
      pending_d = 1'b1;
    end else if (take) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  assign addr = pending_q ? '0 : count_q;

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Shares the SDRAM controller command port between the frame writer and the LCD reader,
// granting whole bursts round-robin with a read-urgency override.
module frame_buffer_arbiter
  import frame_buffer_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH  = 640,
  parameter int unsigned FRAME_HEIGHT = 480,
  parameter int unsigned BURST_LEN    = 32,
  parameter int unsigned ADDR_WIDTH   = 21
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_req,
  input  logic                  wr_sof,
  output logic                  wr_grant,
  output logic                  wr_done,
  input  logic                  rd_req,
  input  logic                  rd_urgent,
  input  logic                  rd_sof,
  output logic                  rd_grant,
  output logic                  rd_done,
  input  logic                  mem_rdy,
  output logic                  mem_cmd_valid,
  output logic                  mem_cmd_write,
  output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
  input  logic                  mem_cmd_ack,
  input  logic                  mem_burst_done,
  output logic                  busy
);

  localparam int unsigned FrameWords = frame_words(FRAME_WIDTH, FRAME_HEIGHT);

  arb_state_t            state_q, state_d;
  requester_t            winner_q, winner_d;
  requester_t            last_served_q, last_served_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic                  start, burst_end;
  logic                  wr_take, rd_take, wr_advance, rd_advance;

  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    last_served_d = last_served_q;
    cmd_addr_d    = cmd_addr_q;
    start         = 1'b0;
    burst_end     = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (mem_rdy && (wr_req || rd_req)) begin
          start         = 1'b1;
          winner_d      = pick_winner(wr_req, rd_req, rd_urgent, last_served_q);
          last_served_d = winner_d;
          cmd_addr_d    = (winner_d == REQ_WRITE) ? wr_addr : rd_addr;
          state_d       = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (mem_cmd_ack) state_d = ARB_WAIT_DONE;
      end
      ARB_WAIT_DONE: begin
        // mem_rdy is deliberately ignored here: a started burst always runs to completion.
        if (mem_burst_done) begin
          burst_end = 1'b1;
          state_d   = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ARB_IDLE;
      winner_q      <= REQ_WRITE;
      last_served_q <= REQ_READ;
      cmd_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      last_served_q <= last_served_d;
      cmd_addr_q    <= cmd_addr_d;
    end
  end

  assign wr_take    = start && (winner_d == REQ_WRITE);
  assign rd_take    = start && (winner_d == REQ_READ);
  assign wr_advance = burst_end && (winner_q == REQ_WRITE);
  assign rd_advance = burst_end && (winner_q == REQ_READ);

  burst_address_counter #(
    .FRAME_WORDS (FrameWords),
    .BURST_LEN   (BURST_LEN),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_wr_addr (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (wr_advance),
    .sof     (wr_sof),
    .take    (wr_take),
    .addr    (wr_addr)
  );

  burst_address_counter #(
    .FRAME_WORDS (FrameWords),
    .BURST_LEN   (BURST_LEN),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_rd_addr (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (rd_advance),
    .sof     (rd_sof),
    .take    (rd_take),
    .addr    (rd_addr)
  );

  assign busy          = (state_q != ARB_IDLE);
  assign mem_cmd_valid = (state_q == ARB_ISSUE);
  assign wr_grant      = busy && (winner_q == REQ_WRITE);
  assign rd_grant      = busy && (winner_q == REQ_READ);
  assign mem_cmd_write = wr_grant;
  assign mem_cmd_addr  = cmd_addr_q;
  // Done is visible in the completion cycle so a requester can drop its request before the
  // following idle cycle arbitrates.
  assign wr_done       = wr_advance;
  assign rd_done       = rd_advance;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter with a simple memory-controller responder model.
module tb_frame_buffer_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_req = 1'b0, wr_sof = 1'b0, rd_req = 1'b0, rd_urgent = 1'b0, rd_sof = 1'b0;
  logic        mem_rdy = 1'b0, mem_cmd_ack = 1'b0, mem_burst_done = 1'b0;
  logic        wr_grant, wr_done, rd_grant, rd_done, mem_cmd_valid, mem_cmd_write, busy;
  logic [20:0] mem_cmd_addr;

  int errors = 0;
  int checks = 0;
  int ack_dly = 2;
  int done_dly = 40;
  int phase = 0;
  int cnt = 0;
  bit sof_on_done = 1'b0;
  bit sof_set = 1'b0;
  int wr_done_cnt = 0;
  int rd_done_cnt = 0;
  logic [31:0] log_q[$];

  frame_buffer_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wr_req         (wr_req),
    .wr_sof         (wr_sof),
    .wr_grant       (wr_grant),
    .wr_done        (wr_done),
    .rd_req         (rd_req),
    .rd_urgent      (rd_urgent),
    .rd_sof         (rd_sof),
    .rd_grant       (rd_grant),
    .rd_done        (rd_done),
    .mem_rdy        (mem_rdy),
    .mem_cmd_valid  (mem_cmd_valid),
    .mem_cmd_write  (mem_cmd_write),
    .mem_cmd_addr   (mem_cmd_addr),
    .mem_cmd_ack    (mem_cmd_ack),
    .mem_burst_done (mem_burst_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Controller model: ack after ack_dly extra cycles of valid, done done_dly cycles later.
  always @(posedge clk) begin
    #1;
    mem_cmd_ack    = 1'b0;
    mem_burst_done = 1'b0;
    if (sof_set) begin
      wr_sof  = 1'b0;
      sof_set = 1'b0;
    end
    if (!reset_n) begin
      phase = 0;
    end else begin
      if (phase == 0 && mem_cmd_valid) begin
        phase = 1;
        cnt   = 0;
      end
      if (phase == 1) begin
        if (cnt == ack_dly) begin
          mem_cmd_ack = 1'b1;
          log_q.push_back({10'd0, mem_cmd_write, mem_cmd_addr});
          phase = 2;
          cnt   = 0;
        end else begin
          cnt++;
        end
      end else if (phase == 2) begin
        if (cnt == done_dly) begin
          mem_burst_done = 1'b1;
          phase = 0;
          if (sof_on_done && mem_cmd_write) begin
            wr_sof      = 1'b1;
            sof_set     = 1'b1;
            sof_on_done = 1'b0;
          end
        end else begin
          cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (wr_done) wr_done_cnt++;
    if (rd_done) rd_done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ent(input bit w, input int a);
    return {10'd0, w, a[20:0]};
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return 'x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for n more done pulses (bounded), then returns just after the next posedge so the
  // caller can change requests before the following idle cycle arbitrates.
  task automatic wait_dones(input string tag, input int n, input int limit);
    int target;
    int k;
    target = wr_done_cnt + rd_done_cnt + n;
    k = 0;
    while ((wr_done_cnt + rd_done_cnt) < target && k < limit) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, 32'(wr_done_cnt + rd_done_cnt >= target), 32'd1);
    tick();
  endtask

  initial begin
    int bad;
    int k;
    int saved;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 32'({wr_grant, wr_done, rd_grant, rd_done, mem_cmd_valid, mem_cmd_write,
                           busy}), 32'd0);
    chk("reset_addr", 32'(mem_cmd_addr), 32'd0);
    tick();
    reset_n = 1'b1;

    // 1: write-only stream, slow controller
    tick();
    mem_rdy = 1'b1;
    wr_req  = 1'b1;
    @(negedge clk);
    chk("latency_n", 32'(mem_cmd_valid), 32'd0);
    @(negedge clk);
    chk("issue_outs", 32'({wr_grant, wr_done, rd_grant, rd_done, mem_cmd_valid, mem_cmd_write,
                           busy}), 32'b1000111);
    chk("issue_addr", 32'(mem_cmd_addr), 32'd0);
    wait_dones("t1_dones", 3, 400);
    wr_req = 1'b0;
    chk("t1_b0", log_at(0), ent(1, 0));
    chk("t1_b1", log_at(1), ent(1, 32));
    chk("t1_b2", log_at(2), ent(1, 64));
    chk("t1_wr_done", 32'(wr_done_cnt), 32'd3);
    chk("t1_rd_done", 32'(rd_done_cnt), 32'd0);

    // 2: both requesting, round-robin (write was served last)
    log_q.delete();
    ack_dly  = 0;
    done_dly = 3;
    wr_req   = 1'b1;
    rd_req   = 1'b1;
    wait_dones("t2_dones", 4, 100);
    wr_req = 1'b0;
    rd_req = 1'b0;
    chk("t2_b0", log_at(0), ent(0, 0));
    chk("t2_b1", log_at(1), ent(1, 96));
    chk("t2_b2", log_at(2), ent(0, 32));
    chk("t2_b3", log_at(3), ent(1, 128));

    // 3: urgent reads starve writes, then alternation resumes write-first
    log_q.delete();
    rd_urgent = 1'b1;
    wr_req    = 1'b1;
    rd_req    = 1'b1;
    wait_dones("t3_urgent", 3, 100);
    rd_urgent = 1'b0;
    wait_dones("t3_resume", 2, 100);
    wr_req = 1'b0;
    rd_req = 1'b0;
    chk("t3_b0", log_at(0), ent(0, 64));
    chk("t3_b1", log_at(1), ent(0, 96));
    chk("t3_b2", log_at(2), ent(0, 128));
    chk("t3_b3", log_at(3), ent(1, 160));
    chk("t3_b4", log_at(4), ent(0, 160));

    // 4: full-frame write from a fresh sof, then wrap
    log_q.delete();
    done_dly = 0;
    wr_sof   = 1'b1;
    tick();
    wr_sof = 1'b0;
    wr_req = 1'b1;
    wait_dones("t4_dones", 9601, 9601 * 4 + 200);
    wr_req = 1'b0;
    chk("t4_count", 32'(log_q.size()), 32'd9601);
    chk("t4_first", log_at(0), ent(1, 0));
    chk("t4_last", log_at(9599), ent(1, 307168));
    chk("t4_wrap", log_at(9600), ent(1, 0));
    bad = 0;
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i] !== ent(1, (i % 9600) * 32)) bad++;
    end
    chk("t4_seq", 32'(bad), 32'd0);

    // 4b: rd_sof during an active read burst
    log_q.delete();
    done_dly = 10;
    rd_req   = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rd_grant && k < 20);
    chk("t4_rd_grant", 32'(rd_grant), 32'd1);
    tick();
    rd_sof = 1'b1;
    tick();
    rd_sof = 1'b0;
    wait_dones("t4_rd_dones", 3, 100);
    rd_req = 1'b0;
    chk("t4_rd_old", log_at(0), ent(0, 192));
    chk("t4_rd_zero", log_at(1), ent(0, 0));
    chk("t4_rd_next", log_at(2), ent(0, 32));

    // 5: wr_sof coincident with the write burst's done
    log_q.delete();
    done_dly    = 5;
    sof_on_done = 1'b1;
    wr_req      = 1'b1;
    wait_dones("t5_dones", 3, 100);
    wr_req = 1'b0;
    chk("t5_b0", log_at(0), ent(1, 32));
    chk("t5_b1", log_at(1), ent(1, 0));
    chk("t5_b2", log_at(2), ent(1, 32));

    // 6: controller not ready
    mem_rdy = 1'b0;
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_cmd_valid || busy || wr_grant || rd_grant) bad++;
    end
    chk("t6_not_rdy", 32'(bad), 32'd0);

    // 6b: asynchronous reset during WAIT_DONE
    log_q.delete();
    done_dly = 20;
    tick();
    mem_rdy = 1'b1;
    k = 0;
    while (log_q.size() < 1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("t6_grant", log_at(0), ent(0, 64));
    chk("t6_wait", 32'({rd_grant, mem_cmd_valid, busy}), 32'b101);
    saved = wr_done_cnt + rd_done_cnt;
    #2;
    reset_n = 1'b0;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    #1;
    chk("t6_rst_outs", 32'({wr_grant, wr_done, rd_grant, rd_done, mem_cmd_valid, mem_cmd_write,
                            busy}), 32'd0);
    chk("t6_rst_addr", 32'(mem_cmd_addr), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_no_done", 32'(wr_done_cnt + rd_done_cnt), 32'(saved));
    tick();
    reset_n = 1'b1;
    log_q.delete();
    done_dly = 0;
    wr_req   = 1'b1;
    rd_req   = 1'b1;
    wait_dones("t6_dones", 2, 100);
    wr_req = 1'b0;
    rd_req = 1'b0;
    chk("t6_post_w", log_at(0), ent(1, 0));
    chk("t6_post_r", log_at(1), ent(0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
